// File: rtl/uart_pkg.sv
// Shared UART settings and transmitter state encodings (8N1, LSB first).
package uart_pkg;

  localparam int unsigned CLK_HZ        = 50_000_000;
  localparam int unsigned BAUD          = 115_200;
  localparam int unsigned BAUD_DIV_DFLT = CLK_HZ / BAUD;  // 434 clk cycles per bit
  localparam int unsigned DATA_BITS     = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } tx_state_e;

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte handshake between game logic (master) and the UART transmitter (slave).
interface uart_transmitter_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data_in;
  logic                 send;
  logic                 ready;
  logic                 busy;

  modport master (output data_in, output send, input ready, input busy);
  modport slave  (input data_in, input send, output ready, output busy);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the optional TX queue; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate count.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still honoured.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter, 8N1, LSB first. Optional TX FIFO enabled by defining
// UART_TX_FIFO_EN; without it the shifter accepts a byte only while idle.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = BAUD_DIV_DFLT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_transmitter_if.slave   bus,
  output logic                tx
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("BAUD_DIV must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  tx_state_e            state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 bit_done;
  logic                 load;
  logic [DATA_BITS-1:0] load_data;

  assign bit_done = (baud_cnt == CNT_LAST);

`ifdef UART_TX_FIFO_EN
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic [DATA_BITS-1:0] fifo_dout;

  // Every byte goes through the FIFO; the shifter pops when idle or at the end of STOP.
  assign fifo_push = bus.send && !fifo_full;
  assign load      = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));
  assign load_data = fifo_dout;
  assign bus.ready = !fifo_full;
  assign bus.busy  = (state != IDLE) || !fifo_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (bus.data_in),
    .pop   (load),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
`else
  assign load      = bus.send && (state == IDLE);
  assign load_data = bus.data_in;
  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state != IDLE);
`endif

  // Frame sequencer: start bit, 8 data bits LSB first, stop bit; tx is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (load) begin
            shift    <= load_data;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (load) begin
              shift   <= load_data;
              bit_idx <= '0;
              tx      <= 1'b0;
              state   <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: a cycle-level frame model predicts
// ready/busy and the start cycle of every frame; a line monitor decodes tx.
module tb_uart_transmitter;

  localparam int BD    = 16;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  logic tx;
  int   cyc = 0;

  uart_transmitter_if u_if ();

  uart_transmitter #(
    .BAUD_DIV   (BD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if),
    .tx    (tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: current frame occupies cycles fs..fe; mq holds queued bytes.
  int         fs = 0;
  int         fe = -1;
  logic [7:0] mq[$];
  logic [7:0] exp_b[$];
  int         exp_t[$];
  bit         last_acc;

  function automatic bit covers(input int c);
    return (c >= fs) && (c <= fe);
  endfunction

  function automatic bit model_ready(input int c);
`ifdef UART_TX_FIFO_EN
    return mq.size() < DEPTH;
`else
    return !covers(c);
`endif
  endfunction

  function automatic bit model_busy(input int c);
    return covers(c) || (mq.size() > 0);
  endfunction

  task automatic start_frame(input int c, input logic [7:0] b);
    fs = c + 1;
    fe = c + 10 * BD;
    exp_b.push_back(b);
    exp_t.push_back(c + 1);
  endtask

  // Model the clock edge at the end of cycle c with the inputs held during c.
  task automatic model_edge(input int c, input bit s, input logic [7:0] d);
`ifdef UART_TX_FIFO_EN
    bit do_push;
    bit do_pop;
    do_push = s && (mq.size() < DEPTH);
    do_pop  = (mq.size() > 0) && (!covers(c) || c == fe);
    if (do_pop) start_frame(c, mq.pop_front());
    if (do_push) mq.push_back(d);
    last_acc = do_push;
`else
    last_acc = s && !covers(c);
    if (last_acc) start_frame(c, d);
`endif
  endtask

  task automatic model_reset();
    fs = 0;
    fe = -1;
    mq.delete();
    exp_b.delete();
    exp_t.delete();
  endtask

  // One cycle: check handshake outputs, then drive inputs for this cycle.
  task automatic step(input bit s, input logic [7:0] d);
    @(negedge clk);
    chk("ready", u_if.ready, model_ready(cyc));
    chk("busy", u_if.busy, model_busy(cyc));
    u_if.send    = s;
    u_if.data_in = d;
    model_edge(cyc, s, d);
  endtask

  // Hold send until the model says the byte was taken.
  task automatic send_hold(input logic [7:0] d);
    int n;
    n = 0;
    do begin
      step(1'b1, d);
      n++;
    end while (!last_acc && n < 30 * BD);
    if (!last_acc) chk("accept_timeout", 32'd1, 32'd0);
    step(1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  // Line monitor: decodes each frame, checks widths, pops and compares the scoreboard.
  int n_frames = 0;
  initial begin : mon
    logic [9:0] fr;
    logic       v;
    int         st;
    int         bad_w;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        st      = cyc;
        bad_w   = 0;
        aborted = 1'b0;
        fr      = '0;
        v       = 1'b0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int k = 0; k < BD && !aborted; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (rst_n !== 1'b1) aborted = 1'b1;
            else if (k == 0) v = tx;
            else if (tx !== v) bad_w++;
          end
          fr[b] = v;
        end
        if (!aborted) begin
          n_frames++;
          if (exp_b.size() == 0) begin
            chk("unexpected_frame", fr[8:1], 32'hFFFF_FFFF);
          end else begin
            chk("frame_byte", fr[8:1], exp_b.pop_front());
            chk("frame_start_cycle", st, exp_t.pop_front());
            chk("start_bit", fr[0], 1'b0);
            chk("stop_bit", fr[9], 1'b1);
            chk("bit_width_glitches", bad_w, 0);
          end
        end
      end
    end
  end

  logic [7:0] lb[4];

  initial begin : main
    int n;
    lb[0] = 8'h00; lb[1] = 8'h7E; lb[2] = 8'hFF; lb[3] = 8'h3C;
    rst_n        = 1'b0;
    u_if.send    = 1'b0;
    u_if.data_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    chk("reset_ready", u_if.ready, 1'b1);
    chk("reset_busy", u_if.busy, 1'b0);
    rst_n = 1'b1;
    model_reset();
    idle(3);

    // Single bytes and all-zero / all-one patterns.
    send_hold(8'h55);
    idle(11 * BD);
    send_hold(8'h00);
    idle(11 * BD);
    send_hold(8'hFF);
    idle(11 * BD);

    // Send while busy is dropped; then held send starts right after ready returns.
    send_hold(8'hA5);
    idle(3 * BD);
    step(1'b1, 8'h3C);
    step(1'b0, 8'h00);
    send_hold(8'h3C);
    idle(11 * BD);

    // Asynchronous reset during data bit 3.
    send_hold(8'h5A);
    idle(4 * BD + BD / 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midframe_reset_tx", tx, 1'b1);
    chk("midframe_reset_ready", u_if.ready, 1'b1);
    chk("midframe_reset_busy", u_if.busy, 1'b0);
    u_if.send = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send_hold(8'h81);
    idle(11 * BD);

    // Loopback byte set, back to back.
    for (int i = 0; i < 4; i++) send_hold(lb[i]);
    idle(11 * BD);

    // Burst on consecutive cycles (exercises the FIFO when present).
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i));
    for (int i = 0; i < 12 * BD; i++) begin
      step(1'b1, 8'h16);
      if (last_acc) break;
    end
    step(1'b0, 8'h00);

    // Randomised traffic.
    for (int i = 0; i < 4000; i++)
      step(($urandom_range(0, 15) == 0), 8'($urandom));

    // Drain with a bound.
    n = 0;
    while ((exp_b.size() != 0 || mq.size() != 0 || cyc <= fe + 2) && n < 80 * BD) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk("drain_scoreboard_empty", exp_b.size(), 0);
    chk("drain_line_idle", tx, 1'b1);
    chk("frames_seen_nonzero", (n_frames > 20), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
